load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Data-memory access unit that consumes the execute stage's results: alu_out is the effective address,
//  rs2_data is the store data, fn3 selects the access size. Runs a request/acknowledge transaction to data
//  memory, aligns and sign-extends load data, and holds the core through stall until the access completes.
//  Sits between execute and writeback; its load_data feeds the writeback mux.
// PARAMETERS
//  N        32   datapath width; fixed at 32 (4 byte lanes)
//  TIMEOUT  255  max cycles in REQ without dmem_ack before abort; 1..2**TW-1
//  TW       8    timeout counter width
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  start        in   1   access request from execute; sampled only in IDLE
//  mem_read     in   1   load access
//  mem_write    in   1   store access
//  fn3          in   3   RV32I funct3 (size/sign)
//  addr         in   N   effective address (alu_out)
//  wdata        in   N   store data (rs2_data)
//  stall        out  1   freeze PC/pipeline while access pending
//  done         out  1   one-cycle pulse: access complete
//  load_data    out  N   aligned, extended load result; valid from done, held until next load done
//  fault        out  1   one-cycle pulse: access rejected or aborted
//  fault_cause  out  2   01 misaligned, 10 illegal op, 11 timeout; held until next fault
//  dmem_req     out  1   memory request, held until dmem_ack
//  dmem_we      out  1   1 = write
//  dmem_addr    out  N   word address, addr with [1:0] forced to 0
//  dmem_be      out  4   byte enables
//  dmem_wdata   out  N   lane-replicated store data
//  dmem_ack     in   1   memory accept/complete; dmem_rdata valid same cycle
//  dmem_rdata   in   N   read data word
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; stall, done, fault, dmem_req, dmem_we = 0; dmem_be = 0;
//   load_data, dmem_addr, dmem_wdata, fault_cause = 0; timeout counter = 0. Reset mid-REQ drops dmem_req
//   at once; the aborted transaction produces no done and no fault.
//  FSM: IDLE -> REQ -> RESP -> IDLE; IDLE -> ERR -> IDLE.
//  IDLE: start=0 or (mem_read=0 and mem_write=0) -> stay, stall=0. Otherwise, checked in this order:
//   mem_read and mem_write both 1, load fn3 in {011,110,111}, store fn3 not in {000,001,010}
//   -> ERR, cause 10. Half access with addr[0]=1, or word access with addr[1:0]!=0 -> ERR, cause 01.
//   Else latch addr/fn3/wdata/direction -> REQ. stall = 1 combinationally this cycle for every start
//   with mem_read or mem_write set, ERR paths included.
//  REQ: dmem_req=1 and stall=1; dmem_addr/be/we/wdata stable from latched values. dmem_ack=1 -> capture
//   lane data -> RESP. Counter increments each REQ cycle without ack; reaching TIMEOUT -> ERR, cause 11.
//  RESP: done=1, stall=0, dmem_req=0 -> IDLE. Store: load_data unchanged. start is not sampled.
//  ERR: fault=1, stall=0, no memory request -> IDLE.
//  Latency: aligned access with ack on the first REQ cycle -> done 2 cycles after start; each wait adds 1.
//  Byte enables, lane a = addr[1:0]: SB 0001<<a, wdata[7:0] on all 4 lanes; SH 0011<<a, wdata[15:0] on
//   both halves; SW 1111.
//  Load: LB/LBU take byte a, sign/zero extended; LH/LHU take half a[1], extended; LW takes the whole word.
//  dmem_ack is ignored outside REQ.
// TESTING
//  LW addr=0x100, ack on 1st REQ cycle, rdata=0xDEADBEEF -> dmem_addr=0x100, be=1111, done @ start+2,
//   load_data=0xDEADBEEF, stall high for 2 cycles.
//  LB addr=0x103, rdata=0x80FF1234 -> be=1000, load_data=0xFFFFFF80; LBU same -> 0x00000080.
//  SH addr=0x202, wdata=0x0000ABCD -> dmem_we=1, be=1100, wdata=0xABCDABCD, done, load_data unchanged.
//  LW addr=0x101 -> no dmem_req, fault pulse next cycle, fault_cause=01; mem_read=mem_write=1 -> cause 10.
//  LH, ack withheld -> dmem_req high TIMEOUT cycles, then fault with cause 11, back to IDLE, stall=0.
//  rst asserted in the 3rd REQ cycle -> dmem_req, stall drop the same cycle; no done/fault after release.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory access unit between execute and writeback. Takes the effective
//   address (alu_out), store data (rs2_data) and funct3 from execute, runs one
//   request/acknowledge transaction to data memory, aligns and extends load
//   data, and holds the pipeline through stall while the access is pending.
//
//   Ports
//     clk, rst            clock (rising edge), async active-high reset
//     start               access request, sampled only in IDLE
//     mem_read/mem_write  access direction
//     fn3                 RV32I funct3 (size / sign)
//     addr, wdata         effective address, store data
//     stall               freeze PC/pipeline while the access is pending
//     done                one-cycle completion pulse
//     load_data           aligned, extended load result (held)
//     fault, fault_cause  one-cycle reject/abort pulse, held cause
//                         (01 misaligned, 10 illegal op, 11 timeout)
//     dmem_*              data-memory request/acknowledge interface
//
//   state | meaning
//   IDLE  | waiting for start; decodes and validates the request
//   REQ   | dmem_req asserted, waiting for dmem_ack or timeout
//   RESP  | done pulse, load_data updated
//   ERR   | fault pulse, fault_cause updated
module load_store_unit #(
    parameter int N       = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [2:0]   fn3,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] wdata,
    output logic         stall,
    output logic         done,
    output logic [N-1:0] load_data,
    output logic         fault,
    output logic [1:0]   fault_cause,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [N-1:0] dmem_addr,
    output logic [3:0]   dmem_be,
    output logic [N-1:0] dmem_wdata,
    input  logic         dmem_ack,
    input  logic [N-1:0] dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    fn3_q;
    logic [1:0]    lane_q;

    logic          is_access;
    logic          illegal;
    logic          misaligned;
    logic [3:0]    be_next;
    logic [N-1:0]  wdata_next;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [N-1:0]  load_ext;

    assign is_access = start && (mem_read || mem_write);

    // stall is combinational so the pipeline freezes in the very cycle start
    // is presented; it also drops at once when reset hits mid-transaction.
    assign stall = ((state == IDLE) && is_access) || (state == REQ);

    always_comb begin
        illegal = 1'b0;
        if (mem_read && mem_write) begin
            illegal = 1'b1;
        end else if (mem_read) begin
            illegal = (fn3 == 3'b011) || (fn3 == 3'b110) || (fn3 == 3'b111);
        end else begin
            illegal = (fn3 != 3'b000) && (fn3 != 3'b001) && (fn3 != 3'b010);
        end
    end

    // fn3[1:0] encodes size for both loads and stores: 00 byte, 01 half, 10 word.
    assign misaligned = ((fn3[1:0] == 2'b01) && addr[0]) ||
                        ((fn3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = wdata;
        case (fn3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << addr[1:0];
                wdata_next = {2{wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wdata;
            end
        endcase
    end

    always_comb begin
        rd_byte = 8'h00;
        case (lane_q)
            2'd0: rd_byte = dmem_rdata[7:0];
            2'd1: rd_byte = dmem_rdata[15:8];
            2'd2: rd_byte = dmem_rdata[23:16];
            2'd3: rd_byte = dmem_rdata[31:24];
            default: rd_byte = 8'h00;
        endcase
        rd_half  = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_ext = dmem_rdata;
        case (fn3_q)
            3'b000:  load_ext = {{(N-8){rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{(N-16){rd_half[15]}}, rd_half};
            3'b100:  load_ext = {{(N-8){1'b0}}, rd_byte};
            3'b101:  load_ext = {{(N-16){1'b0}}, rd_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            fn3_q       <= '0;
            lane_q      <= '0;
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            load_data   <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= 4'b0000;
            dmem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    if (is_access) begin
                        if (illegal) begin
                            state       <= ERR;
                            fault       <= 1'b1;
                            fault_cause <= 2'b10;
                        end else if (misaligned) begin
                            state       <= ERR;
                            fault       <= 1'b1;
                            fault_cause <= 2'b01;
                        end else begin
                            state      <= REQ;
                            tmo_cnt    <= '0;
                            fn3_q      <= fn3;
                            lane_q     <= addr[1:0];
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= {addr[N-1:2], 2'b00};
                            dmem_be    <= be_next;
                            dmem_wdata <= wdata_next;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        state    <= RESP;
                        done     <= 1'b1;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (!dmem_we) begin
                            load_data <= load_ext;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Last permitted REQ cycle without ack: abort.
                        state       <= ERR;
                        fault       <= 1'b1;
                        fault_cause <= 2'b11;
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                ERR: begin
                    fault <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, mem_read, mem_write;
    logic [2:0]  fn3;
    logic [31:0] addr, wdata;
    logic        stall, done, fault;
    logic [31:0] load_data;
    logic [1:0]  fault_cause;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_load = 32'h0;
    logic [1:0]  exp_cause = 2'b00;

    load_store_unit #(.N(32), .TIMEOUT(TIMEOUT), .TW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_read(mem_read),
        .mem_write(mem_write), .fn3(fn3), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .load_data(load_data), .fault(fault),
        .fault_cause(fault_cause), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f);
        return 1 << (f % 4);
    endfunction

    // 0 = accepted, 1 = misaligned, 2 = illegal
    function automatic int classify(input logic rd, input logic wr, input logic [2:0] f,
                                    input logic [31:0] a);
        if (rd && wr) return 2;
        if (rd && (f == 3 || f == 6 || f == 7)) return 2;
        if (wr && f > 2) return 2;
        if (a % nbytes(f) != 0) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f, input logic [31:0] a);
        int n = nbytes(f);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] f, input logic [31:0] d);
        int n = nbytes(f);
        if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_ld(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] r);
        int          n = nbytes(f);
        logic [31:0] mask, v;
        if (n == 4) return r;
        mask = (n == 1) ? 32'hFF : 32'hFFFF;
        v = (r >> ((a % 4) * 8)) & mask;
        if (f < 4 && v > (mask >> 1)) v = v | ~mask;
        return v;
    endfunction

    // ---------------- directed step tasks ----------------
    task automatic run_ok(input logic rd, input logic wr, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d,
                          input int waits, input logic [31:0] r);
        tick;
        start = 1; mem_read = rd; mem_write = wr; fn3 = f; addr = a; wdata = d;
        #2;
        chk("stall_at_start", stall, 1);
        chk("req_at_start", dmem_req, 0);
        tick;
        start = 0; mem_read = 0; mem_write = 0; addr = $urandom; wdata = $urandom;
        for (int i = 0; i <= waits; i++) begin
            dmem_ack   = (i == waits);
            dmem_rdata = (i == waits) ? r : $urandom;
            #2;
            chk("req_high", dmem_req, 1);
            chk("stall_req", stall, 1);
            chk("done_early", done, 0);
            if (i == 0) begin
                chk("dmem_addr", dmem_addr, a & 32'hFFFF_FFFC);
                chk("dmem_be", dmem_be, model_be(f, a));
                chk("dmem_we", dmem_we, wr);
                if (wr) chk("dmem_wdata", dmem_wdata, model_wd(f, d));
            end
            tick;
        end
        dmem_ack = 1; dmem_rdata = $urandom;   // must be ignored outside REQ
        if (rd) exp_load = model_ld(f, a, r);
        #2;
        chk("done_pulse", done, 1);
        chk("stall_resp", stall, 0);
        chk("req_resp", dmem_req, 0);
        chk("load_data", load_data, exp_load);
        tick;
        dmem_ack = 0;
        #2;
        chk("done_clear", done, 0);
        chk("load_data_held", load_data, exp_load);
    endtask

    task automatic run_fault(input logic rd, input logic wr, input logic [2:0] f,
                             input logic [31:0] a, input logic [1:0] cause);
        tick;
        start = 1; mem_read = rd; mem_write = wr; fn3 = f; addr = a; wdata = $urandom;
        #2;
        chk("stall_fault_start", stall, 1);
        tick;
        start = 0; mem_read = 0; mem_write = 0;
        exp_cause = cause;
        #2;
        chk("fault_pulse", fault, 1);
        chk("fault_cause", fault_cause, exp_cause);
        chk("fault_no_req", dmem_req, 0);
        chk("fault_stall", stall, 0);
        chk("fault_no_done", done, 0);
        tick;
        #2;
        chk("fault_clear", fault, 0);
        chk("fault_cause_held", fault_cause, exp_cause);
    endtask

    task automatic run_noop;
        tick;
        start = 1; mem_read = 0; mem_write = 0; fn3 = 3'($urandom); addr = $urandom;
        #2;
        chk("noop_stall", stall, 0);
        tick;
        start = 0;
        chk("noop_req", dmem_req, 0);
        chk("noop_fault", fault, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        rst = 1; start = 0; mem_read = 0; mem_write = 0; fn3 = 0;
        addr = 0; wdata = 0; dmem_ack = 0; dmem_rdata = 0;
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_cause", fault_cause, 0);
        @(negedge clk);
        rst = 0;

        run_ok(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
        chk("lw_value", load_data, 32'hDEAD_BEEF);
        run_ok(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_1234);
        chk("lb_value", load_data, 32'hFFFF_FF80);
        run_ok(1, 0, 3'b100, 32'h103, 32'h0, 2, 32'h80FF_1234);
        chk("lbu_value", load_data, 32'h0000_0080);
        run_ok(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 0, 32'h1111_2222);
        chk("sh_keeps_load", load_data, 32'h0000_0080);
        run_fault(1, 0, 3'b010, 32'h101, 2'b01);
        run_fault(1, 1, 3'b010, 32'h100, 2'b10);
        run_fault(1, 0, 3'b110, 32'h100, 2'b10);
        run_fault(0, 1, 3'b100, 32'h100, 2'b10);
        run_noop;

        // Timeout: LH with ack withheld.
        tick;
        start = 1; mem_read = 1; fn3 = 3'b001; addr = 32'h302;
        tick;
        start = 0; mem_read = 0; dmem_ack = 0;
        cnt = 0;
        while (dmem_req === 1'b1 && cnt < TIMEOUT + 5) begin
            cnt++;
            tick;
        end
        exp_cause = 2'b11;
        chk("timeout_req_cycles", cnt, TIMEOUT);
        chk("timeout_fault", fault, 1);
        chk("timeout_cause", fault_cause, exp_cause);
        tick;
        chk("timeout_fault_clear", fault, 0);
        chk("timeout_stall", stall, 0);

        // Reset in the 3rd REQ cycle.
        tick;
        start = 1; mem_read = 1; fn3 = 3'b010; addr = 32'h400;
        tick;
        start = 0; mem_read = 0; dmem_ack = 0;
        tick;
        tick;
        rst = 1;
        #1;
        chk("rst_mid_req", dmem_req, 0);
        chk("rst_mid_stall", stall, 0);
        tick;
        rst = 0;
        exp_load = 0;
        exp_cause = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("post_rst_done", done, 0);
            chk("post_rst_fault", fault, 0);
        end
        chk("post_rst_load", load_data, exp_load);

        // Randomized accesses against the model.
        for (int k = 0; k < 40; k++) begin
            logic        rd, wr;
            logic [2:0]  f;
            logic [31:0] a;
            int          cls;
            rd = 1'($urandom);
            wr = 1'($urandom);
            f  = 3'($urandom);
            a  = $urandom;
            if (!rd && !wr) begin
                run_noop;
            end else begin
                cls = classify(rd, wr, f, a);
                if (cls == 0)
                    run_ok(rd, wr, f, a, $urandom, int'($urandom_range(0, 3)), $urandom);
                else
                    run_fault(rd, wr, f, a, 2'(cls == 1 ? 1 : 2));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
